avg_frame_feeder: RTL
=====================

Name: avg_frame_feeder

Overview:
- Upstream stage of the averaging unit. Accepts a free-running valid/ready sample stream into a small FIFO and cuts it into frames of programmable length.
- For each frame it pulses `start`, then drives `data_first`/`data_last`/`data_in` back-to-back, one sample per cycle, with no gaps.
- It then waits for the averager's `done` or `TO` and presents the result on a valid/ready output.

Parameters:
- NOF_BITS, 32, sample width; result is NOF_BITS+1.
- FIFO_DEPTH, 16, input buffer entries; power of 2, ≥2; also the maximum frame length.
- LEN_W, $clog2(FIFO_DEPTH+1), width of frame_len.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input sample valid
- in_data  in  NOF_BITS  input sample
- in_ready  out  1  FIFO not full
- frame_len  in  LEN_W  samples per frame; sampled when a frame is launched
- avg_start  out  1  one-cycle start pulse to averager
- avg_data_first  out  1  first sample of frame
- avg_data_last  out  1  last sample of frame
- avg_data_in  out  NOF_BITS  sample to averager
- avg_busy  in  1  averager busy
- avg_done  in  1  averager result pulse
- avg_TO  in  1  averager timeout pulse
- avg_data_out  in  NOF_BITS+1  averager result
- res_valid  out  1  result available
- res_data  out  NOF_BITS+1  captured average
- res_to  out  1  result came from a timeout; res_data is 0 in that case
- res_ready  in  1  consumer accepts result

Behaviour:
- Reset (async, rst=1):
  - FIFO empty; state IDLE.
  - All outputs 0, except in_ready=1.
  - Reset mid-frame abandons the frame; no result is produced.
- FIFO:
  - Push when in_valid & in_ready.
  - in_ready = (count < FIFO_DEPTH), taken from the count register.
  - Push and pop in the same cycle leave count unchanged.
  - in_valid while full is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Frame length:
  - len_eff = min(frame_len, FIFO_DEPTH).
  - frame_len=0 never launches a frame; the FIFO just fills.
  - len_eff is latched at launch; later frame_len changes do not affect the frame in flight.
- FSM (all avg_* and res_* outputs registered):
  - IDLE: if len_eff≠0 & count≥len_eff & !avg_busy → START.
  - START: avg_start=1 for exactly one cycle (cycle T) → STREAM.
  - STREAM: cycles T+1..T+len_eff, one FIFO pop per cycle.
    - avg_data_first=1 only in T+1.
    - avg_data_last=1 only in T+len_eff; both are set in T+1 when len_eff=1.
    - avg_data_in = popped sample.
    - The FIFO never underflows, because count≥len_eff was checked at launch.
    - Pushes continue during streaming.
    - After the last sample → WAIT_RES.
  - WAIT_RES:
    - on avg_done: res_data=avg_data_out, res_to=0 → OUT.
    - on avg_TO: res_data=0, res_to=1 → OUT.
    - if both assert in the same cycle, avg_done wins.
  - OUT: res_valid=1, with res_data and res_to held stable until res_ready. On the res_ready cycle, res_valid drops the next cycle → IDLE.
- The next frame can launch no earlier than the cycle after result acceptance, and only when avg_busy=0.
- Latency for len_eff=N:
  - avg_start 1 cycle after the launch condition.
  - last sample N cycles after avg_start.
  - res_valid 1 cycle after avg_done.
- Frame integrity: samples reach the averager in FIFO order; no sample is dropped or duplicated across frames.

Decomposition:
- Shared package avg_pkg:
  - feeder state enum (IDLE, START, STREAM, WAIT_RES, OUT).
  - averager timeout constant, shared with the averager.
  - default NOF_BITS.
- One sub-module: avg_in_fifo, a synchronous FIFO with count output, parameterised by NOF_BITS and FIFO_DEPTH.
- FSM, length latch and result capture stay in avg_frame_feeder.

Test Plan:
- frame_len=4; push 10,20,30,40 → avg_start pulse, then first with 10 and last with 40 in 4 consecutive cycles; averager model returns 25 → res_valid=1, res_data=25, res_to=0.
- frame_len=1; push 7 → first and last both high with data 7 in the cycle after avg_start; result 7.
- frame_len=0 with 16 pushes → no avg_start; in_ready=0 after the 16th push; a 17th in_valid is ignored.
- frame_len=20 (above FIFO_DEPTH=16) → frame of 16 samples; last asserted on the 16th streamed cycle.
- Model asserts avg_TO instead of avg_done → res_to=1, res_data=0; res_ready held low for 5 cycles → res_valid and res_data stable throughout.
- rst asserted mid-STREAM → all outputs 0 immediately and in_ready=1; after release a fresh 2-sample frame completes correctly.

Source files
------------

// File: rtl/avg_pkg.sv
// =============================================================================
// avg_pkg : shared types and constants for the averaging unit
// Revision: 1.0
// =============================================================================
`default_nettype none

package avg_pkg;

    localparam int unsigned AVG_NOF_BITS       = 32;
    localparam int unsigned AVG_TIMEOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_STREAM   = 3'd2,
        ST_WAIT_RES = 3'd3,
        ST_OUT      = 3'd4
    } feeder_state_e;

endpackage

`default_nettype wire

// File: rtl/avg_in_fifo.sv
// =============================================================================
// avg_in_fifo : synchronous FIFO with occupancy count and show-ahead read port
// Revision: 1.0
// =============================================================================
`default_nettype none

module avg_in_fifo
    import avg_pkg::*;
#(
    parameter int NOF_BITS   = AVG_NOF_BITS,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push_i,
    input  logic [NOF_BITS-1:0] push_data_i,
    input  logic                pop_i,
    output logic [NOF_BITS-1:0] pop_data_o,
    output logic [CNT_W-1:0]    count_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [NOF_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_d;

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

`default_nettype wire

// File: rtl/avg_frame_feeder.sv
// =============================================================================
// avg_frame_feeder : buffers a sample stream, cuts it into frames for the
//                    averager and returns the averager result on valid/ready
// Revision: 1.0
// =============================================================================
`default_nettype none

module avg_frame_feeder
    import avg_pkg::*;
#(
    parameter int NOF_BITS   = AVG_NOF_BITS,
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [NOF_BITS-1:0] in_data,
    output logic                in_ready,
    input  logic [LEN_W-1:0]    frame_len,
    output logic                avg_start,
    output logic                avg_data_first,
    output logic                avg_data_last,
    output logic [NOF_BITS-1:0] avg_data_in,
    input  logic                avg_busy,
    input  logic                avg_done,
    input  logic                avg_TO,
    input  logic [NOF_BITS:0]   avg_data_out,
    output logic                res_valid,
    output logic [NOF_BITS:0]   res_data,
    output logic                res_to,
    input  logic                res_ready
);

    feeder_state_e       state_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    sent_q;
    logic                start_q;
    logic                first_q;
    logic                last_q;
    logic [NOF_BITS-1:0] data_q;
    logic                res_valid_q;
    logic [NOF_BITS:0]   res_data_q;
    logic                res_to_q;

    logic                w_push;
    logic                w_pop;
    logic [NOF_BITS-1:0] w_rd_data;
    logic [LEN_W-1:0]    w_count;
    logic [LEN_W-1:0]    w_len_eff;
    logic                w_launch;

    assign in_ready  = (w_count < LEN_W'(FIFO_DEPTH));
    assign w_push    = in_valid & in_ready;
    assign w_len_eff = (frame_len > LEN_W'(FIFO_DEPTH)) ? LEN_W'(FIFO_DEPTH) : frame_len;
    assign w_launch  = (w_len_eff != '0) && (w_count >= w_len_eff) && !avg_busy;
    // One pop while presenting each sample; START pops the first one.
    assign w_pop     = (state_q == ST_START) || ((state_q == ST_STREAM) && (sent_q != len_q));

    avg_in_fifo #(
        .NOF_BITS   (NOF_BITS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (LEN_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (w_push),
        .push_data_i (in_data),
        .pop_i       (w_pop),
        .pop_data_o  (w_rd_data),
        .count_o     (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            sent_q      <= '0;
            start_q     <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            data_q      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_to_q    <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_launch) begin
                        len_q   <= w_len_eff;
                        start_q <= 1'b1;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    first_q <= 1'b1;
                    last_q  <= (len_q == LEN_W'(1));
                    data_q  <= w_rd_data;
                    sent_q  <= LEN_W'(1);
                    state_q <= ST_STREAM;
                end
                ST_STREAM: begin
                    first_q <= 1'b0;
                    if (sent_q == len_q) begin
                        last_q  <= 1'b0;
                        data_q  <= '0;
                        state_q <= ST_WAIT_RES;
                    end else begin
                        last_q  <= ((sent_q + LEN_W'(1)) == len_q);
                        data_q  <= w_rd_data;
                        sent_q  <= sent_q + LEN_W'(1);
                    end
                end
                ST_WAIT_RES: begin
                    // A simultaneous done and timeout resolves as done.
                    if (avg_done) begin
                        res_valid_q <= 1'b1;
                        res_data_q  <= avg_data_out;
                        res_to_q    <= 1'b0;
                        state_q     <= ST_OUT;
                    end else if (avg_TO) begin
                        res_valid_q <= 1'b1;
                        res_data_q  <= '0;
                        res_to_q    <= 1'b1;
                        state_q     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        res_data_q  <= '0;
                        res_to_q    <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign avg_start      = start_q;
    assign avg_data_first = first_q;
    assign avg_data_last  = last_q;
    assign avg_data_in    = data_q;
    assign res_valid      = res_valid_q;
    assign res_data       = res_data_q;
    assign res_to         = res_to_q;

endmodule

`default_nettype wire
